// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer
//   Drives an external pipelined ALU and a single-port RAM through batches of
//   operations. Each op: load ALU inputs, wait EXEC_LAT cycles for the result,
//   write it to RAM, read it back, optionally compare, advance the address.
//
// Ports
//   clk, reset           : single clock, synchronous active-high reset
//   start, abort         : begin a batch (IDLE only) / kill the current batch
//   base_addr, op_count  : first RAM address and number of ops in the batch
//   verify_en            : enable readback compare in CHECK
//   alu_result           : external ALU result register
//   mem_rdata            : RAM read data, valid the cycle after a read
//   mem_CEB, mem_WEB     : RAM chip enable (active low), write enable (0=write)
//   mem_addr             : registered RAM address
//   input_ld, result_ld  : ALU input / result register load strobes
//   busy, done           : not-IDLE flag / one-cycle normal completion pulse
//   err, err_addr        : sticky readback mismatch flag / first failing address
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | ALU computing, EXEC_LAT cycles, result_ld in the last one
// WRITE | RAM write of alu_result at mem_addr
// READ  | RAM read at the same mem_addr
// CHECK | compare readback, then next op or finish
// DONE  | one-cycle done pulse
module alu_mem_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int EXEC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] op_count,
    input  logic              verify_en,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_CEB,
    output logic              mem_WEB,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              input_ld,
    output logic              result_ld,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  exec_cnt;
    logic [ADDR_W-1:0] remaining;
    logic              accept;
    logic              more_ops;

    // abort in IDLE also blocks acceptance so input_ld and the transition agree
    assign accept   = (state == IDLE) && start && !abort;
    assign more_ops = (remaining > ADDR_W'(1));
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        input_ld   = 1'b0;
        result_ld  = 1'b0;
        mem_CEB    = 1'b1;
        mem_WEB    = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_count != '0) begin
                        // operands are captured in the same cycle start is accepted
                        input_ld   = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            EXEC: begin
                if (exec_cnt == '0) begin
                    result_ld  = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_CEB    = 1'b0;
                mem_WEB    = 1'b0;
                state_next = READ;
            end
            READ: begin
                mem_CEB    = 1'b0;
                state_next = CHECK;
            end
            CHECK: begin
                if (more_ops) begin
                    input_ld   = 1'b1;
                    state_next = EXEC;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            input_ld  = 1'b0;
            result_ld = 1'b0;
            mem_CEB   = 1'b1;
            done      = 1'b0;
            if (state != IDLE) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            exec_cnt  <= '0;
            remaining <= '0;
            mem_addr  <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            state <= state_next;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            err      <= 1'b0;
                            err_addr <= '0;
                            if (op_count != '0) begin
                                mem_addr  <= base_addr;
                                remaining <= op_count;
                                exec_cnt  <= CNT_LOAD;
                            end
                        end
                    end
                    EXEC: begin
                        if (exec_cnt != '0) begin
                            exec_cnt <= exec_cnt - 1'b1;
                        end
                    end
                    CHECK: begin
                        if (verify_en && (mem_rdata != alu_result)) begin
                            err <= 1'b1;
                            if (!err) begin
                                err_addr <= mem_addr;
                            end
                        end
                        if (more_ops) begin
                            mem_addr  <= mem_addr + 1'b1;   // wraps modulo 2^ADDR_W
                            remaining <= remaining - 1'b1;
                            exec_cnt  <= CNT_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mem_sequencer.sv
module tb_alu_mem_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic [7:0] op_count;
    logic       verify_en;
    logic [7:0] alu_result;
    logic [7:0] mem_rdata;
    logic       mem_CEB;
    logic       mem_WEB;
    logic [7:0] mem_addr;
    logic       input_ld;
    logic       result_ld;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_addr;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [7:0] ram [256];
    logic       corrupt_en;
    logic [7:0] bad_a, bad_b;

    logic       cap_il  [64];
    logic       cap_rl  [64];
    logic       cap_ceb [64];
    logic       cap_web [64];
    logic       cap_dn  [64];
    logic [7:0] cap_adr [64];

    alu_mem_sequencer #(.ADDR_W(8), .DATA_W(8), .EXEC_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .op_count(op_count), .verify_en(verify_en),
        .alu_result(alu_result), .mem_rdata(mem_rdata),
        .mem_CEB(mem_CEB), .mem_WEB(mem_WEB), .mem_addr(mem_addr),
        .input_ld(input_ld), .result_ld(result_ld), .busy(busy), .done(done),
        .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // RAM model: write alu_result, read back next cycle, optionally corrupted
    always @(posedge clk) begin
        if (mem_CEB === 1'b0) begin
            if (mem_WEB === 1'b0)
                ram[mem_addr] <= alu_result;
            else if (corrupt_en && (mem_addr == bad_a || mem_addr == bad_b))
                mem_rdata <= ram[mem_addr] ^ 8'hFF;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] b, input logic [7:0] n);
        base_addr = b;
        op_count  = n;
        start     = 1'b1;
    endtask

    // entered 1 time unit after a rising edge; records cycles 0..n-1
    task automatic run_capture(input int n);
        for (int i = 0; i < n; i++) begin
            #2;
            cap_il[i]  = input_ld;
            cap_rl[i]  = result_ld;
            cap_ceb[i] = mem_CEB;
            cap_web[i] = mem_WEB;
            cap_dn[i]  = done;
            cap_adr[i] = mem_addr;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_n, rl_n, dn_n, il_n, ceb_n, d0;
        logic [7:0] wr_adr [8];

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; op_count = '0; verify_en = 1'b1;
        alu_result = 8'h5A; corrupt_en = 1'b0; bad_a = 8'h00; bad_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_ceb", mem_CEB, 1);
        chk("rst_web", mem_WEB, 1);
        chk("rst_il", input_ld, 0);
        chk("rst_rl", result_ld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_err", err, 0);
        step();

        // single op at 0x10: timeline check
        launch(8'h10, 8'd1);
        run_capture(8);
        rl_n = 0; dn_n = 0;
        for (int i = 0; i < 8; i++) begin
            rl_n += int'(cap_rl[i]);
            dn_n += int'(cap_dn[i]);
        end
        chk("a_il_c0", cap_il[0], 1);
        chk("a_il_c1", cap_il[1], 0);
        chk("a_rl_c2", cap_rl[2], 1);
        chk("a_rl_cnt", rl_n, 1);
        chk("a_wr_c3", {cap_ceb[3], cap_web[3], cap_adr[3]}, {2'b00, 8'h10});
        chk("a_rd_c4", {cap_ceb[4], cap_web[4], cap_adr[4]}, {2'b01, 8'h10});
        chk("a_ceb_c5", cap_ceb[5], 1);
        chk("a_done_c6", cap_dn[6], 1);
        chk("a_done_cnt", dn_n, 1);
        chk("a_err", err, 0);
        chk("a_busy_end", busy, 0);

        // wrap-around batch
        launch(8'hFE, 8'd3);
        alu_result = 8'h3C;
        run_capture(18);
        wr_n = 0; dn_n = 0;
        for (int i = 0; i < 18; i++) begin
            if (cap_ceb[i] === 1'b0 && cap_web[i] === 1'b0 && wr_n < 8) begin
                wr_adr[wr_n] = cap_adr[i];
                wr_n++;
            end
            dn_n += int'(cap_dn[i]);
        end
        chk("b_wr_cnt", wr_n, 3);
        chk("b_wr0", wr_adr[0], 8'hFE);
        chk("b_wr1", wr_adr[1], 8'hFF);
        chk("b_wr2", wr_adr[2], 8'h00);
        chk("b_done_c16", cap_dn[16], 1);
        chk("b_done_cnt", dn_n, 1);
        chk("b_err", err, 0);
        chk("b_addr_end", mem_addr, 8'h00);

        // corruption on ops 2 and 4 of a 0x20 batch
        corrupt_en = 1'b1; bad_a = 8'h21; bad_b = 8'h23;
        launch(8'h20, 8'd4);
        run_capture(23);
        chk("c_err", err, 1);
        chk("c_err_addr", err_addr, 8'h21);
        chk("c_addr_end", mem_addr, 8'h23);
        chk("c_done_c21", cap_dn[21], 1);
        corrupt_en = 1'b0;

        // zero-length batch: clears err, no RAM access, mem_addr held
        launch(8'h99, 8'd0);
        run_capture(4);
        il_n = 0; ceb_n = 0;
        for (int i = 0; i < 4; i++) begin
            il_n  += int'(cap_il[i]);
            ceb_n += int'(!cap_ceb[i]);
        end
        chk("d_done_c0", cap_dn[0], 0);
        chk("d_done_c1", cap_dn[1], 1);
        chk("d_il_cnt", il_n, 0);
        chk("d_ceb_cnt", ceb_n, 0);
        chk("d_err", err, 0);
        chk("d_addr_held", mem_addr, 8'h23);

        // abort during op 2 WRITE
        d0 = done_cnt;
        launch(8'h40, 8'd3);
        repeat (8) begin
            step();
            start = 1'b0;
        end
        chk("e_pre_ceb", mem_CEB, 0);
        chk("e_pre_addr", mem_addr, 8'h41);
        abort = 1'b1;
        #1;
        chk("e_ab_ceb", mem_CEB, 1);
        chk("e_ab_il", input_ld, 0);
        step();
        abort = 1'b0;
        #1;
        chk("e_idle", busy, 0);
        chk("e_no_done", done_cnt, d0);
        step();
        launch(8'h50, 8'd1);
        run_capture(8);
        chk("e_new_il", cap_il[0], 1);
        chk("e_new_wr", {cap_ceb[3], cap_web[3], cap_adr[3]}, {2'b00, 8'h50});
        chk("e_new_done", cap_dn[6], 1);

        // reset mid-EXEC; start pulse while busy must be ignored
        launch(8'h60, 8'd3);
        step();
        start = 1'b1;
        base_addr = 8'h77;
        step();
        start = 1'b0;
        #1;
        chk("f_rl_c2", result_ld, 1);
        chk("f_addr_c2", mem_addr, 8'h60);
        reset = 1'b1;
        step();
        chk("f_busy", busy, 0);
        chk("f_ceb", mem_CEB, 1);
        chk("f_web", mem_WEB, 1);
        chk("f_il", input_ld, 0);
        chk("f_rl", result_ld, 0);
        chk("f_done", done, 0);
        chk("f_addr", mem_addr, 8'h00);
        chk("f_err", err, 0);
        chk("f_err_addr", err_addr, 8'h00);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) step();
        chk("f_stay_idle", busy, 0);
        chk("f_no_done", done_cnt, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
